// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl
//   Sequences decode/rename recovery after a retire-time flush. A flush is
//   acknowledged from IDLE and then moves through these steps:
//     1. stall rename and wait for execute to drain;
//     2. pulse the restore strobe (RAT, free list and busy table restore
//        from arch_rat);
//     3. wait a minimum refill time plus the free-list rebuild;
//     4. redirect fetch to the captured PC.
//   A retired halt parks rename permanently (until rst).
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush_req/pc      ROB flush request (level, held until flush_ack) and target PC
//   halt_retired      retired halt pulse
//   exec_busy         execute may still produce wakeups
//   fl_rebuilt        free list rebuild complete
//   flush_ack         one-cycle accept pulse
//   rename_stall      holds decode/rename off
//   recov_arch_st     one-cycle restore pulse
//   fetch_redirect    one-cycle fetch restart pulse, target on redirect_pc
//   halted            sticky halt indication
//   drain_timeout     sticky: drain was cut short by the timeout
//   recov_count       completed recoveries, saturating
module rename_recovery_ctrl #(
  parameter int REFILL_CYCLES = 4,
  parameter int DRAIN_MAX     = 255,
  parameter int PC_W          = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic [PC_W-1:0]  flush_pc,
  input  logic             halt_retired,
  input  logic             exec_busy,
  input  logic             fl_rebuilt,
  output logic             flush_ack,
  output logic             rename_stall,
  output logic             recov_arch_st,
  output logic             fetch_redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             halted,
  output logic             drain_timeout,
  output logic [CNT_W-1:0] recov_count
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam int RW = $clog2(REFILL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_RESTORE, S_REFILL, S_REDIRECT, S_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [RW-1:0]    refill_cnt_q, refill_cnt_d;
  logic             flush_ack_q, flush_ack_d;
  logic             rename_stall_q, rename_stall_d;
  logic             recov_arch_st_q, recov_arch_st_d;
  logic             fetch_redirect_q, fetch_redirect_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             halted_q, halted_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic [CNT_W-1:0] recov_count_q, recov_count_d;

  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    refill_cnt_d    = refill_cnt_q;
    flush_ack_d     = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    drain_timeout_d = drain_timeout_q;
    recov_count_d   = recov_count_q;
    unique case (state_q)
      S_IDLE: begin
        // The ack cycle itself is spent in IDLE (stall still low); the
        // request is still held by the ROB then and must not be re-acked.
        // A halt seen alongside a flush is wrong-path and is dropped.
        if (flush_ack_q) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (flush_req) begin
          flush_ack_d   = 1'b1;
          redirect_pc_d = flush_pc;
        end else if (halt_retired) begin
          state_d = S_HALTED;
        end
      end
      S_DRAIN: begin
        if (!exec_busy) begin
          state_d = S_RESTORE;
        end else if (drain_cnt_q == DW'(DRAIN_MAX - 1)) begin
          state_d         = S_RESTORE;
          drain_timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_RESTORE: begin
        state_d      = S_REFILL;
        refill_cnt_d = '0;
      end
      S_REFILL: begin
        // Minimum time and rebuild are both required; the counter parks at
        // its terminal value while the free list is still rebuilding.
        if (refill_cnt_q >= RW'(REFILL_CYCLES - 1) && fl_rebuilt) begin
          state_d = S_REDIRECT;
          if (recov_count_q != '1) recov_count_d = recov_count_q + CNT_W'(1);
        end else if (refill_cnt_q < RW'(REFILL_CYCLES - 1)) begin
          refill_cnt_d = refill_cnt_q + RW'(1);
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      S_HALTED:   state_d = S_HALTED;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so each is a clean
    // flop output that lines up with the state it describes.
    rename_stall_d   = (state_d != S_IDLE);
    recov_arch_st_d  = (state_d == S_RESTORE);
    fetch_redirect_d = (state_d == S_REDIRECT);
    halted_d         = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      drain_cnt_q      <= '0;
      refill_cnt_q     <= '0;
      flush_ack_q      <= 1'b0;
      rename_stall_q   <= 1'b0;
      recov_arch_st_q  <= 1'b0;
      fetch_redirect_q <= 1'b0;
      redirect_pc_q    <= '0;
      halted_q         <= 1'b0;
      drain_timeout_q  <= 1'b0;
      recov_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      refill_cnt_q     <= refill_cnt_d;
      flush_ack_q      <= flush_ack_d;
      rename_stall_q   <= rename_stall_d;
      recov_arch_st_q  <= recov_arch_st_d;
      fetch_redirect_q <= fetch_redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      halted_q         <= halted_d;
      drain_timeout_q  <= drain_timeout_d;
      recov_count_q    <= recov_count_d;
    end
  end

  assign flush_ack      = flush_ack_q;
  assign rename_stall   = rename_stall_q;
  assign recov_arch_st  = recov_arch_st_q;
  assign fetch_redirect = fetch_redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign halted         = halted_q;
  assign drain_timeout  = drain_timeout_q;
  assign recov_count    = recov_count_q;

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Bench for rename_recovery_ctrl: directed vector table, hand sequences for
// drain/refill/reset/collision/halt corners, and a random phase. Every cycle
// is also compared against a timestamp-based reference model.
module tb_rename_recovery_ctrl;
  localparam int PC_W = 32, CNT_W = 16, REFILL = 4, DMAX = 255;

  logic clk = 1'b0, rst;
  logic flush_req, halt_retired, exec_busy, fl_rebuilt;
  logic [PC_W-1:0] flush_pc, redirect_pc, redirect_pc2;
  logic flush_ack, rename_stall, recov_arch_st, fetch_redirect, halted, drain_timeout;
  logic flush_ack2, rename_stall2, recov_arch_st2, fetch_redirect2, halted2, drain_timeout2;
  logic [CNT_W-1:0] recov_count;
  logic [1:0] recov_count2;

  rename_recovery_ctrl #(.REFILL_CYCLES(REFILL), .DRAIN_MAX(DMAX), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_pc(flush_pc), .halt_retired(halt_retired),
    .exec_busy(exec_busy), .fl_rebuilt(fl_rebuilt), .flush_ack(flush_ack), .rename_stall(rename_stall),
    .recov_arch_st(recov_arch_st), .fetch_redirect(fetch_redirect), .redirect_pc(redirect_pc),
    .halted(halted), .drain_timeout(drain_timeout), .recov_count(recov_count));

  // Narrow counter copy for the saturation case.
  rename_recovery_ctrl #(.REFILL_CYCLES(REFILL), .DRAIN_MAX(DMAX), .PC_W(PC_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_pc(flush_pc), .halt_retired(halt_retired),
    .exec_busy(exec_busy), .fl_rebuilt(fl_rebuilt), .flush_ack(flush_ack2), .rename_stall(rename_stall2),
    .recov_arch_st(recov_arch_st2), .fetch_redirect(fetch_redirect2), .redirect_pc(redirect_pc2),
    .halted(halted2), .drain_timeout(drain_timeout2), .recov_count(recov_count2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a recovery is described by the cycle numbers of its
  // ack, restore pulse and redirect; outputs are derived from those dates.
  int n, m_ack, m_res, m_red, m_cnt;
  bit m_rec, m_halt, m_to;
  logic [PC_W-1:0] m_pc;

  task automatic model_reset();
    n = 0; m_ack = -1; m_res = -1; m_red = -1; m_cnt = 0;
    m_rec = 0; m_halt = 0; m_to = 0; m_pc = '0;
  endtask

  // Advance from cycle p (whose inputs are currently applied) to cycle n.
  task automatic model_step();
    int p;
    p = n; n = n + 1;
    if (m_halt) begin
    end else if (m_rec) begin
      if (p == m_red) m_rec = 0;
      else if (m_res < 0) begin
        if (p > m_ack && (!exec_busy || p - m_ack == DMAX)) begin
          m_res = p + 1;
          if (exec_busy) m_to = 1;
        end
      end else if (m_red < 0 && p >= m_res + REFILL && fl_rebuilt) begin
        m_red = p + 1; m_cnt++;
      end
    end else if (flush_req) begin
      m_rec = 1; m_ack = p + 1; m_res = -1; m_red = -1; m_pc = flush_pc;
    end else if (halt_retired) m_halt = 1;
  endtask

  task automatic check_model();
    logic [5:0] e;
    e = {n == m_ack, m_halt || (m_rec && n > m_ack), n == m_res, n == m_red, m_halt, m_to};
    chk("model_ctl", {flush_ack, rename_stall, recov_arch_st, fetch_redirect, halted, drain_timeout}, e);
    chk("model_ctl_n2", {flush_ack2, rename_stall2, recov_arch_st2, fetch_redirect2, halted2, drain_timeout2}, e);
    chk("model_pc", redirect_pc, m_pc);
    chk("model_cnt", {recov_count2, recov_count}, {(m_cnt > 3) ? 2'd3 : 2'(m_cnt), 16'(m_cnt)});
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (rst) model_reset(); else model_step();
    check_model();
  endtask

  task automatic bits(input string nm, input logic [3:0] e);
    chk(nm, {flush_ack, rename_stall, recov_arch_st, fetch_redirect}, e);
  endtask

  task automatic wait_redirect(input string nm);
    int k;
    k = 0;
    while (!fetch_redirect && k < 600) begin cyc(); k++; end
    chk({nm, "_redirect_seen"}, fetch_redirect, 1'b1);
    cyc();
  endtask

  typedef struct {
    logic flush; logic [PC_W-1:0] pc; logic busy, fl, halt;
    logic [3:0] exp; // {ack, stall, restore, redirect}
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt_ack, cnt_red;
    bit hold;
    tbl[0] = '{1'b1, 32'h0000_1040, 1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[1] = '{1'b1, 32'h0000_1040, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 4'b0110};
    for (int i = 3; i < 7; i++) tbl[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0101};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000};

    rst = 1; flush_req = 0; flush_pc = '0; halt_retired = 0; exec_busy = 0; fl_rebuilt = 0;
    model_reset();
    cyc(); cyc();
    chk("reset_state", {flush_ack, rename_stall, recov_arch_st, fetch_redirect, halted, drain_timeout,
                        redirect_pc, recov_count}, '0);
    rst = 0;
    cyc();

    // Clean flush, table driven.
    for (int i = 0; i < 9; i++) begin
      flush_req = tbl[i].flush; flush_pc = tbl[i].pc; exec_busy = tbl[i].busy;
      fl_rebuilt = tbl[i].fl; halt_retired = tbl[i].halt;
      cyc();
      bits($sformatf("clean_row%0d", i), tbl[i].exp);
    end
    chk("clean_pc", redirect_pc, 32'h0000_1040);
    chk("clean_count", recov_count, 16'd1);

    // Drain held by exec_busy for 10 cycles from the ack cycle.
    flush_req = 1; flush_pc = 32'h2000; exec_busy = 1; fl_rebuilt = 1;
    cyc();
    bits("drain_ack", 4'b1000);
    cnt_red = 0;
    for (int i = 0; i < 10; i++) begin
      flush_req = (i == 0);
      cyc();
      cnt_red += recov_arch_st;
    end
    chk("drain_no_early_restore", cnt_red, 0);
    exec_busy = 0;
    cyc();
    chk("drain_restore_after_fall", recov_arch_st, 1'b1);
    wait_redirect("drain");

    // Drain timeout with exec_busy stuck.
    flush_req = 1; flush_pc = 32'h3000; exec_busy = 1;
    cyc();
    bits("to_ack", 4'b1000);
    k = 0;
    do begin flush_req = (k == 0); cyc(); k++; end while (!recov_arch_st && k < 400);
    chk("to_latency", k, DMAX + 1);
    chk("to_flag", drain_timeout, 1'b1);
    exec_busy = 0;
    wait_redirect("to");
    chk("to_sticky", drain_timeout, 1'b1);

    // Refill held by fl_rebuilt.
    flush_req = 1; flush_pc = 32'h4000; fl_rebuilt = 0;
    cyc(); cyc();
    flush_req = 0;
    cyc();
    chk("refill_restore", recov_arch_st, 1'b1);
    cnt_red = 0;
    for (int i = 0; i < 20; i++) begin cyc(); cnt_red += fetch_redirect; end
    chk("refill_hold", cnt_red, 0);
    fl_rebuilt = 1;
    cyc();
    chk("refill_release", fetch_redirect, 1'b1);
    chk("refill_pc", redirect_pc, 32'h4000);
    cyc();

    // Reset in the middle of REFILL.
    flush_req = 1; flush_pc = 32'h5000; fl_rebuilt = 0;
    cyc(); cyc();
    flush_req = 0;
    cyc(); cyc(); cyc();
    rst = 1;
    cyc();
    chk("rst_mid_outputs", {rename_stall, recov_arch_st, fetch_redirect, recov_count}, '0);
    rst = 0; fl_rebuilt = 1;
    cyc();
    bits("rst_mid_idle", 4'b0000);
    for (int i = 0; i < 5; i++) cyc();

    // Flush and halt together; second flush during REFILL.
    flush_req = 1; halt_retired = 1; flush_pc = 32'h6000; fl_rebuilt = 0;
    cyc();
    bits("coll_ack", 4'b1000);
    halt_retired = 0;
    cyc();
    chk("coll_not_halted", halted, 1'b0);
    flush_req = 0;
    cyc(); cyc();
    flush_req = 1; flush_pc = 32'h7000;
    cnt_ack = 0;
    for (int i = 0; i < 10; i++) begin cyc(); cnt_ack += flush_ack; end
    chk("coll_no_ack_busy", cnt_ack, 0);
    fl_rebuilt = 1;
    cyc();
    chk("coll_first_redirect", {fetch_redirect, redirect_pc}, {1'b1, 32'h6000});
    cyc();
    bits("coll_idle", 4'b0000);
    cyc();
    bits("coll_second_ack", 4'b1000);
    chk("coll_second_pc", redirect_pc, 32'h7000);
    cyc();
    flush_req = 0;
    wait_redirect("coll2");
    chk("coll_count", recov_count, 16'd2);

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 900; i++) begin
      if (!flush_req && $urandom_range(0, 7) == 0) begin flush_req = 1; flush_pc = $urandom; end
      exec_busy    = ($urandom_range(0, 3) != 0);
      fl_rebuilt   = ($urandom_range(0, 2) != 0);
      halt_retired = m_rec && ($urandom_range(0, 15) == 0);
      cyc();
      if (hold) begin flush_req = 0; hold = 0; end
      if (flush_ack) hold = 1;
    end
    halt_retired = 0; exec_busy = 0; fl_rebuilt = 1;
    k = 0;
    while ((m_rec || flush_req) && k < 600) begin
      cyc(); k++;
      if (hold) begin flush_req = 0; hold = 0; end
      if (flush_ack) hold = 1;
    end
    chk("rand_settled", {m_rec, flush_req}, 2'b00);
    cyc();
    chk("sat_count", recov_count2, 2'd3);

    // Halt parks rename for good.
    halt_retired = 1;
    cyc();
    chk("halt_state", {halted, rename_stall}, 2'b11);
    halt_retired = 0; flush_req = 1; flush_pc = 32'h8000;
    cnt_ack = 0; k = 0;
    for (int i = 0; i < 30; i++) begin cyc(); cnt_ack += flush_ack; k += rename_stall; end
    chk("halt_no_ack", cnt_ack, 0);
    chk("halt_stall_held", k, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
